// File: rtl/cfg_image_sequencer.sv
// cfg_image_sequencer
//   Boots the FPGA from a selectable flash image page. After power-up it waits
//   for the PFL's initial image, reads the boot record through the flash
//   controller, then reconfigures the FPGA from the recorded page. It retries
//   a bounded number of times, falls back to the factory page, and writes the
//   boot record back only when the page in use differs from the recorded one.
//
// Ports
//   clkin_max_100    : single clock, all logic posedge
//   sys_reset        : synchronous active-high reset
//   fpga_conf_done   : FPGA CONF_DONE
//   fpga_statusn     : FPGA nSTATUS (low = configuration error)
//   reconfig_req     : one-cycle request to advance to the next page (IDLE only)
//   rd_compl/wr_compl: flash controller boot-record read/write complete (level)
//   boot_page        : page from the boot record, valid with rd_compl
//   pfl_flash_access : 1 = PFL owns flash, 0 = flash controller owns it
//   fl_rd_req_n      : boot-record read request (active low)
//   fl_wr_req_n      : boot-record write request (active low)
//   wr_page          : page value written into the boot record
//   fpga_pgm         : page presented to the PFL
//   pfl_nreconfigure : reconfigure pulse to the PFL (active low)
//   pfl_nreset       : PFL reset (active low)
//   cfg_fail         : sticky fallback / terminal-error flag
//   state_dbg        : current state encoding for the LEDs
module cfg_image_sequencer #(
  parameter int unsigned NUM_PAGES    = 3,
  parameter int unsigned PAGE_W       = 2,
  parameter int unsigned FACTORY_PAGE = 0,
  parameter int unsigned CFG_PULSE    = 16777215,
  parameter int unsigned RST_PULSE    = 16777215,
  parameter int unsigned WAIT_CYCLES  = 268435455,
  parameter int unsigned MAX_RETRY    = 2
) (
  input  logic              clkin_max_100,
  input  logic              sys_reset,
  input  logic              fpga_conf_done,
  input  logic              fpga_statusn,
  input  logic              reconfig_req,
  input  logic              rd_compl,
  input  logic              wr_compl,
  input  logic [PAGE_W-1:0] boot_page,
  output logic              pfl_flash_access,
  output logic              fl_rd_req_n,
  output logic              fl_wr_req_n,
  output logic [PAGE_W-1:0] wr_page,
  output logic [PAGE_W-1:0] fpga_pgm,
  output logic              pfl_nreconfigure,
  output logic              pfl_nreset,
  output logic              cfg_fail,
  output logic [3:0]        state_dbg
);

  localparam int unsigned LIM_A     = (CFG_PULSE > RST_PULSE) ? CFG_PULSE : RST_PULSE;
  localparam int unsigned MAX_LIMIT = (LIM_A > WAIT_CYCLES) ? LIM_A : WAIT_CYCLES;
  localparam int unsigned CNT_W     = (MAX_LIMIT > 1) ? $clog2(MAX_LIMIT) : 1;
  localparam int unsigned RTRY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0]  CFG_LAST  = CNT_W'(CFG_PULSE - 1);
  localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [PAGE_W-1:0] FACT      = PAGE_W'(FACTORY_PAGE);
  localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NUM_PAGES - 1);
  localparam logic [PAGE_W:0]   NPAGES_X  = (PAGE_W + 1)'(NUM_PAGES);
  localparam logic [RTRY_W-1:0] RETRY_MAX = RTRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    BOOT_WAIT = 3'd0,
    READ_REC  = 3'd1,
    PULSE_CFG = 3'd2,
    PULSE_RST = 3'd3,
    WAIT_CFG  = 3'd4,
    WR_REC    = 3'd5,
    IDLE      = 3'd6,
    ERROR     = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PAGE_W-1:0]   cur_page_q, cur_page_d;
  logic [PAGE_W-1:0]   rec_page_q, rec_page_d;
  logic [RTRY_W-1:0]   retry_q, retry_d;
  logic                cfg_fail_q, cfg_fail_d;
  logic                access_q, access_d;
  logic                rd_n_q, rd_n_d;
  logic                wr_n_q, wr_n_d;
  logic                nrecfg_q, nrecfg_d;
  logic                nrst_q, nrst_d;
  logic [PAGE_W-1:0]   pgm_q, pgm_d;
  logic [PAGE_W-1:0]   wr_page_q, wr_page_d;
  logic                cfg_ok, cfg_bad;

  // Next state and bookkeeping registers
  always_comb begin
    state_d    = state_q;
    cur_page_d = cur_page_q;
    rec_page_d = rec_page_q;
    retry_d    = retry_q;
    cfg_fail_d = cfg_fail_q;
    // Success is tested first so it wins over a timeout in the final cycle.
    cfg_ok     = fpga_conf_done && fpga_statusn;
    cfg_bad    = !fpga_statusn || (cnt_q == WAIT_LAST);

    unique case (state_q)
      BOOT_WAIT: if (fpga_conf_done) state_d = READ_REC;
      READ_REC: begin
        if (rd_compl) begin
          if ({1'b0, boot_page} >= NPAGES_X) begin
            cur_page_d = FACT;
            rec_page_d = FACT;
          end else begin
            cur_page_d = boot_page;
            rec_page_d = boot_page;
          end
          retry_d = '0;
          state_d = PULSE_CFG;
        end
      end
      PULSE_CFG: if (cnt_q == CFG_LAST) state_d = PULSE_RST;
      PULSE_RST: if (cnt_q == RST_LAST) state_d = WAIT_CFG;
      WAIT_CFG: begin
        if (cfg_ok) begin
          state_d = (cur_page_q != rec_page_q) ? WR_REC : IDLE;
        end else if (cfg_bad) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = PULSE_CFG;
          end else if (cur_page_q != FACT) begin
            cur_page_d = FACT;
            retry_d    = '0;
            cfg_fail_d = 1'b1;
            state_d    = PULSE_CFG;
          end else begin
            cfg_fail_d = 1'b1;
            state_d    = ERROR;
          end
        end
      end
      WR_REC: begin
        if (wr_compl) begin
          rec_page_d = cur_page_q;
          state_d    = IDLE;
        end
      end
      IDLE: begin
        if (reconfig_req) begin
          cur_page_d = (cur_page_q == LAST_PAGE) ? '0 : cur_page_q + 1'b1;
          retry_d    = '0;
          state_d    = PULSE_CFG;
        end
      end
      ERROR: state_d = ERROR;
      default: state_d = BOOT_WAIT;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // exactly with the state register (pulse widths equal state residency).
  always_comb begin
    cnt_d     = '0;
    if (state_d == state_q) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    access_d  = !((state_d == READ_REC) || (state_d == WR_REC));
    rd_n_d    = (state_d != READ_REC);
    wr_n_d    = (state_d != WR_REC);
    nrecfg_d  = (state_d != PULSE_CFG);
    nrst_d    = (state_d != PULSE_RST);
    pgm_d     = (state_d == PULSE_CFG) ? cur_page_d : pgm_q;
    wr_page_d = (state_d == WR_REC)    ? cur_page_d : wr_page_q;
  end

  always_ff @(posedge clkin_max_100) begin
    if (sys_reset) begin
      state_q    <= BOOT_WAIT;
      cnt_q      <= '0;
      cur_page_q <= FACT;
      rec_page_q <= FACT;
      retry_q    <= '0;
      cfg_fail_q <= 1'b0;
      access_q   <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      nrecfg_q   <= 1'b1;
      nrst_q     <= 1'b1;
      pgm_q      <= FACT;
      wr_page_q  <= FACT;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_page_q <= cur_page_d;
      rec_page_q <= rec_page_d;
      retry_q    <= retry_d;
      cfg_fail_q <= cfg_fail_d;
      access_q   <= access_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      nrecfg_q   <= nrecfg_d;
      nrst_q     <= nrst_d;
      pgm_q      <= pgm_d;
      wr_page_q  <= wr_page_d;
    end
  end

  assign pfl_flash_access = access_q;
  assign fl_rd_req_n      = rd_n_q;
  assign fl_wr_req_n      = wr_n_q;
  assign wr_page          = wr_page_q;
  assign fpga_pgm         = pgm_q;
  assign pfl_nreconfigure = nrecfg_q;
  assign pfl_nreset       = nrst_q;
  assign cfg_fail         = cfg_fail_q;
  assign state_dbg        = {1'b0, state_q};

endmodule

// File: tb/tb_cfg_image_sequencer.sv
// Randomized bench for cfg_image_sequencer. A reactive environment plays the
// FPGA and flash controller; a page/retry model predicts pages, pulse widths,
// WAIT_CFG lengths, write-backs, fallback and terminal error.
module tb_cfg_image_sequencer;
  localparam int NP = 3;
  localparam int PW = 2;
  localparam int CP = 4;
  localparam int RP = 4;
  localparam int WC = 32;
  localparam int MR = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          sys_reset, conf_done, statusn, reconfig_req, rd_compl, wr_compl;
  logic [PW-1:0] boot_page;
  logic          access, rd_n, wr_n, nrecfg, nrst, cfg_fail;
  logic [PW-1:0] wr_page, pgm;
  logic [3:0]    st;

  int nchk = 0;
  int nerr = 0;

  // Behavioural model of the page selection rules
  int m_cur, m_rec, m_retry;
  bit m_fail;

  cfg_image_sequencer #(
    .NUM_PAGES(NP), .PAGE_W(PW), .FACTORY_PAGE(0), .CFG_PULSE(CP),
    .RST_PULSE(RP), .WAIT_CYCLES(WC), .MAX_RETRY(MR)
  ) dut (
    .clkin_max_100(clk), .sys_reset(sys_reset), .fpga_conf_done(conf_done),
    .fpga_statusn(statusn), .reconfig_req(reconfig_req), .rd_compl(rd_compl),
    .wr_compl(wr_compl), .boot_page(boot_page), .pfl_flash_access(access),
    .fl_rd_req_n(rd_n), .fl_wr_req_n(wr_n), .wr_page(wr_page), .fpga_pgm(pgm),
    .pfl_nreconfigure(nrecfg), .pfl_nreset(nrst), .cfg_fail(cfg_fail),
    .state_dbg(st)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_st(input int s, input int budget, input string tag);
    int n = 0;
    while (st !== 4'(s) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, st, s);
  endtask

  task automatic chk_reset();
    chk("rst_acc", access, 1);
    chk("rst_rd", rd_n, 1);
    chk("rst_wr", wr_n, 1);
    chk("rst_nrecfg", nrecfg, 1);
    chk("rst_nrst", nrst, 1);
    chk("rst_pgm", pgm, 0);
    chk("rst_wrpage", wr_page, 0);
    chk("rst_fail", cfg_fail, 0);
    chk("rst_state", st, 0);
  endtask

  // outc: 0 success, 1 nSTATUS error, 2 timeout, 3 reset during WAIT_CFG
  task automatic do_attempt(input int page, input int outc, input int d, input bit ign);
    int n;
    wait_st(2, 60, "cfg_enter");
    conf_done = 1'b0;
    statusn   = 1'b1;
    chk("pgm", pgm, page);
    n = 0;
    while (nrecfg === 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("cfg_width", n, CP);
    n = 0;
    while (nrst === 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("rst_width", n, RP);
    chk("wait_enter", st, 4);
    n = 0;
    while (st === 4'd4 && n < 40) begin
      reconfig_req = ign && (n == 0);
      if (n == d && outc == 0) conf_done = 1'b1;
      if (n == d && outc == 1) statusn = 1'b0;
      if (n == d && outc == 3) begin
        sys_reset = 1'b1;
        tick();
        reconfig_req = 1'b0;
        chk_reset();
        break;
      end
      tick();
      n++;
    end
    reconfig_req = 1'b0;
    statusn      = 1'b1;
    if (outc != 3) chk("wait_len", n, (outc == 2) ? WC : d + 1);
  endtask

  initial begin
    sys_reset = 1'b1; conf_done = 1'b0; statusn = 1'b1; reconfig_req = 1'b0;
    rd_compl = 1'b0; wr_compl = 1'b0; boot_page = '0;
    for (int run = 0; run < 14; run++) begin
      int bp;
      bit pre;
      bit err;
      sys_reset = 1'b1; conf_done = 1'b0; statusn = 1'b1;
      rd_compl = 1'b0; wr_compl = 1'b0; reconfig_req = 1'b0;
      tick();
      chk_reset();
      sys_reset = 1'b0;
      reconfig_req = 1'b1;
      tick();
      reconfig_req = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      chk("boot_wait", st, 0);

      bp  = (run < 4) ? run : $urandom_range(0, 3);
      pre = ($urandom_range(0, 3) == 0);
      if (pre) begin
        rd_compl  = 1'b1;
        boot_page = PW'(bp);
      end
      conf_done = 1'b1;
      wait_st(1, 4, "rd_enter");
      chk("rd_req_lo", rd_n, 0);
      chk("rd_acc_lo", access, 0);
      if (!pre) begin
        repeat ($urandom_range(0, 3)) tick();
        rd_compl  = 1'b1;
        boot_page = PW'(bp);
      end
      tick();
      chk("rd_exit", st, 2);
      chk("rd_req_hi", rd_n, 1);
      chk("rd_acc_hi", access, 1);
      rd_compl  = 1'b0;
      boot_page = PW'($urandom_range(0, 3));

      m_cur   = (bp < NP) ? bp : 0;
      m_rec   = m_cur;
      m_retry = 0;
      m_fail  = 1'b0;
      err     = 1'b0;

      for (int a = 0; a < 12; a++) begin
        int w, outc, d;
        bit ign;
        w    = $urandom_range(0, 9);
        outc = (w < 5) ? 0 : (w < 7) ? 1 : 2;
        if (run == 5 && a == 1) outc = 3;
        d    = ($urandom_range(0, 3) == 0) ? WC - 1 : $urandom_range(0, WC - 1);
        ign  = ($urandom_range(0, 3) == 0);
        do_attempt(m_cur, outc, d, ign);
        if (outc == 3) break;
        if (outc == 0) begin
          if (m_cur != m_rec) begin
            chk("wr_enter", st, 5);
            chk("wr_req_lo", wr_n, 0);
            chk("wr_acc_lo", access, 0);
            chk("wr_page", wr_page, m_cur);
            repeat ($urandom_range(0, 3)) tick();
            wr_compl = 1'b1;
            tick();
            wr_compl = 1'b0;
            m_rec = m_cur;
          end
          chk("idle", st, 6);
          chk("idle_wr_hi", wr_n, 1);
          chk("idle_acc", access, 1);
          chk("idle_fail", cfg_fail, m_fail);
          if ($urandom_range(0, 4) == 0) break;
          repeat ($urandom_range(0, 3)) tick();
          chk("idle_hold", st, 6);
          reconfig_req = 1'b1;
          tick();
          reconfig_req = 1'b0;
          m_cur   = (m_cur == NP - 1) ? 0 : m_cur + 1;
          m_retry = 0;
        end else begin
          if (m_retry < MR) begin
            m_retry++;
          end else if (m_cur != 0) begin
            m_cur   = 0;
            m_retry = 0;
            m_fail  = 1'b1;
          end else begin
            m_fail = 1'b1;
            err    = 1'b1;
          end
          chk("fail_flag", cfg_fail, m_fail);
          if (err) begin
            chk("error", st, 7);
            reconfig_req = 1'b1;
            tick();
            reconfig_req = 1'b0;
            repeat (4) tick();
            chk("error_hold", st, 7);
            chk("error_fail", cfg_fail, 1);
            chk("error_acc", access, 1);
            break;
          end else begin
            chk("retry", st, 2);
          end
        end
      end
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cfg_image_sequencer.md
# cfg_image_sequencer

Parametrised configuration-image sequencer for the MAX II system CPLD. After power-up it reads the boot record from flash through the flash controller, then drives the PFL to reconfigure the FPGA from the selected page. It supports N image pages, bounded retries, fallback to the factory page, and user-requested page advance, and writes the boot record back only when it changes. It sits between the top-level flash-access mux, the PFL instance and the flash controller, and replaces the fixed 3-page sequencer FSM.

## Interface
- NUM_PAGES, 3: number of image pages; valid page indices are 0..NUM_PAGES-1.
- PAGE_W, 2: page index width; must satisfy 2^PAGE_W >= NUM_PAGES.
- FACTORY_PAGE, 0: fallback page index.
- CFG_PULSE, 16777215: cycles pfl_nreconfigure is held low.
- RST_PULSE, 16777215: cycles pfl_nreset is held low.
- WAIT_CYCLES, 268435455: configuration timeout, in cycles.
- MAX_RETRY, 2: extra attempts on the same page before fallback.
- clkin_max_100 in 1: single clock; all logic is posedge.
- sys_reset in 1: synchronous, active-high reset.
- fpga_conf_done in 1: FPGA CONF_DONE.
- fpga_statusn in 1: FPGA nSTATUS (low = configuration error).
- reconfig_req in 1: one-cycle pulse requesting the next page.
- rd_compl in 1: flash controller has finished the boot-record read (level).
- wr_compl in 1: flash controller has finished the boot-record write (level).
- boot_page in PAGE_W: page value from the boot record; valid when rd_compl=1.
- pfl_flash_access out 1: 1 = PFL owns flash, 0 = flash controller owns it.
- fl_rd_req_n out 1: active-low boot-record read request.
- fl_wr_req_n out 1: active-low boot-record write request.
- wr_page out PAGE_W: page value to write into the boot record.
- fpga_pgm out PAGE_W: page presented to the PFL.
- pfl_nreconfigure out 1: active-low reconfigure pulse to the PFL.
- pfl_nreset out 1: active-low PFL reset.
- cfg_fail out 1: sticky flag; set when fallback or a terminal error occurs.
- state_dbg out 4: current state encoding, driven to the LEDs.

## Operation
- States and encodings: BOOT_WAIT=0, READ_REC=1, PULSE_CFG=2, PULSE_RST=3, WAIT_CFG=4, WR_REC=5, IDLE=6, ERROR=7.
- BOOT_WAIT: wait for fpga_conf_done=1 (power-up image loaded by the PFL), then go to READ_REC.
- READ_REC: pfl_flash_access=0 and fl_rd_req_n=0.
  - On rd_compl=1, latch cur_page and rec_page from boot_page.
  - If boot_page >= NUM_PAGES, latch FACTORY_PAGE into both instead.
  - Then go to PULSE_CFG with retry_cnt=0.
- PULSE_CFG: fpga_pgm=cur_page; pfl_nreconfigure=0 for exactly CFG_PULSE cycles; then PULSE_RST.
- PULSE_RST: pfl_nreset=0 for exactly RST_PULSE cycles; then WAIT_CFG.
- WAIT_CFG: count up to WAIT_CYCLES.
  - Success: fpga_conf_done=1 and fpga_statusn=1. Go to WR_REC if cur_page != rec_page, otherwise IDLE.
  - Failure: counter expiry or fpga_statusn=0, evaluated in priority order:
    - retry_cnt < MAX_RETRY: retry_cnt+1, go to PULSE_CFG with the same page.
    - Else if cur_page != FACTORY_PAGE: cur_page=FACTORY_PAGE, retry_cnt=0, cfg_fail=1, go to PULSE_CFG.
    - Else: cfg_fail=1, go to ERROR.
- WR_REC: pfl_flash_access=0, fl_wr_req_n=0, wr_page=cur_page. On wr_compl=1, set rec_page=cur_page and go to IDLE.
- IDLE: PFL owns flash. On reconfig_req, set cur_page = (cur_page==NUM_PAGES-1) ? 0 : cur_page+1, retry_cnt=0, then PULSE_CFG.
- ERROR: terminal; left only by sys_reset.
- reconfig_req is ignored in every state except IDLE.
- Counters are sized to $clog2 of the largest count limit and do not wrap; each is cleared on every state entry.

## Timing
- All outputs are registered and change one cycle after the sampling edge.
- Reset values:
  - state=BOOT_WAIT, pfl_flash_access=1.
  - fl_rd_req_n=1, fl_wr_req_n=1, pfl_nreconfigure=1, pfl_nreset=1.
  - fpga_pgm=FACTORY_PAGE, wr_page=FACTORY_PAGE, cfg_fail=0, state_dbg=0.
- Read handshake: fl_rd_req_n and pfl_flash_access drop on the cycle after READ_REC entry. Both return high on the cycle after rd_compl is sampled high.
- Write handshake: the same rule applies to fl_wr_req_n with wr_compl.
- Pulse widths are exact: pfl_nreconfigure is low for CFG_PULSE cycles and pfl_nreset for RST_PULSE cycles, with no gap between the two pulses.
- Simultaneous success and timeout in the final WAIT_CFG cycle: success wins.
- sys_reset mid-operation: returns to BOOT_WAIT within one cycle and releases all requests high. The flash controller must abort on request release.
- rd_compl or wr_compl held high across a state entry: acted on in the first cycle of the state.

## Test plan
(Parameters for all scenarios: NUM_PAGES=3, CFG_PULSE=4, RST_PULSE=4, WAIT_CYCLES=32, MAX_RETRY=1.)
- Normal boot: conf_done=1, rd_compl with boot_page=2, conf_done high during WAIT_CFG -> fpga_pgm=2, 4-cycle nreconfigure and nreset pulses, no WR_REC, state_dbg=6.
- Invalid record: boot_page=3 -> cur_page=0, fpga_pgm=0, configuration proceeds normally.
- Retry then fallback: page 1, conf_done held 0 -> two timeouts of 32 cycles on page 1, then fpga_pgm=0 and cfg_fail=1. Success on page 0 -> WR_REC with wr_page=0, then IDLE.
- Factory failure: page 0, fpga_statusn=0 -> one retry, then ERROR (state_dbg=7). reconfig_req is ignored.
- Page advance with wrap: in IDLE with cur_page=2, pulse reconfig_req -> fpga_pgm=0. On success, fl_wr_req_n goes low with wr_page=0; it releases after wr_compl.
- Reset mid-WAIT_CFG: assert sys_reset -> next cycle all outputs at reset values and state_dbg=0.
